// File: rtl/sfq_or2t_readout.sv
// sfq_or2t_readout: synchronous readout stage behind a clocked RSFQ OR2T cell.
// The OR2T clock line and output line are toggle-encoded (one SFQ pulse per
// transition). The two lines are synchronised and edge-detected, and the
// out-pulses seen between consecutive clock pulses are folded into one
// result bit per evaluation window. WORD_W bits are packed into a word and
// handed out over valid/ready. Protocol errors go to a saturating counter.
module sfq_or2t_readout #(
  parameter int WORD_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              sfq_clk,
  input  logic              sfq_out,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overrun,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  localparam int BC_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_CLK,
    S_CAPTURE
  } state_t;

  // Synchroniser and edge-history flops
  logic              r_clk_s1, r_clk_s2, r_clk_prev;
  logic              r_out_s1, r_out_s2, r_out_prev;
  logic [1:0]        r_warm;

  // Capture state
  state_t            r_state;
  logic [BC_W-1:0]   r_bitcnt;
  logic [WORD_W-1:0] r_shreg;
  logic [1:0]        r_win_cnt;

  // Registered outputs
  logic [WORD_W-1:0] r_word_data;
  logic              r_word_valid;
  logic              r_overrun;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_busy;

  // Combinational helpers
  logic              w_sync_ok;
  logic              w_clk_pulse;
  logic              w_out_pulse;
  logic [1:0]        w_win_total;
  logic              w_bit;
  logic              w_dbl;
  logic              w_last;
  logic [WORD_W-1:0] w_word;
  logic              w_handshake;
  logic              w_word_done;
  logic              w_err_inc;
  logic              w_err_max;

  // Two-flop synchronisers plus one history flop per line. r_warm holds off
  // pulse detection until the pipeline has refilled after reset, so a level
  // left on a line across reset is absorbed instead of read as a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b0;
      r_clk_s2   <= 1'b0;
      r_clk_prev <= 1'b0;
      r_out_s1   <= 1'b0;
      r_out_s2   <= 1'b0;
      r_out_prev <= 1'b0;
      r_warm     <= 2'd0;
    end else begin
      r_clk_s1   <= sfq_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_out_s1   <= sfq_out;
      r_out_s2   <= r_out_s1;
      r_out_prev <= r_out_s2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  // Pulse detection, window tally and word assembly
  always_comb begin
    w_sync_ok   = (r_warm == 2'd3);
    w_clk_pulse = (r_clk_s2 ^ r_clk_prev) & w_sync_ok;
    w_out_pulse = (r_out_s2 ^ r_out_prev) & w_sync_ok;
    // An out pulse coincident with a clock pulse belongs to the closing window
    w_win_total = r_win_cnt + {1'b0, w_out_pulse};
    w_bit       = |w_win_total;
    w_dbl       = w_win_total[1];
    w_last      = (r_bitcnt == BC_W'(WORD_W - 1));
    w_word      = r_shreg;
    w_word[r_bitcnt] = w_bit;
    w_handshake = r_word_valid & word_ready;
    w_word_done = arm & (r_state == S_CAPTURE) & w_clk_pulse & w_last;
    w_err_inc   = arm & (((r_state == S_WAIT_CLK) & w_out_pulse) |
                         ((r_state == S_CAPTURE) & w_clk_pulse & w_dbl));
    w_err_max   = (r_err_cnt == '1);
  end

  // Capture FSM with registered word/handshake/error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_shreg      <= '0;
      r_win_cnt    <= 2'd0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_cnt    <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bitcnt  <= '0;
          r_shreg   <= '0;
          r_win_cnt <= 2'd0;
          if (arm) begin
            r_state <= S_WAIT_CLK;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_CLK: begin
          if (!arm) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_clk_pulse) begin
            r_state   <= S_CAPTURE;
            r_win_cnt <= 2'd0;
          end
        end
        S_CAPTURE: begin
          if (!arm) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_win_cnt <= 2'd0;
          end else if (w_clk_pulse) begin
            r_win_cnt <= 2'd0;
            if (w_last) begin
              r_bitcnt <= '0;
              r_shreg  <= '0;
            end else begin
              r_bitcnt <= r_bitcnt + BC_W'(1);
              r_shreg  <= w_word;
            end
          end else begin
            // Only "none", "one" or "two or more" matter, so saturate at 2
            r_win_cnt <= w_win_total[1] ? 2'd2 : w_win_total;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_word_done) begin
        if (!r_word_valid || w_handshake) begin
          r_word_data  <= w_word;
          r_word_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_handshake) begin
        r_word_valid <= 1'b0;
      end

      if (w_err_inc && !w_err_max) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign overrun    = r_overrun;
  assign err_cnt    = r_err_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sfq_or2t_readout.sv
// Testbench for sfq_or2t_readout: table-driven capture vectors, hand-written
// corner sequences and randomized window streams checked against a
// window-level reference model.
module tb_sfq_or2t_readout;

  localparam int WW = 8;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          sfq_clk = 1'b0;
  logic          sfq_out = 1'b0;
  logic          word_ready = 1'b0;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          overrun;
  logic [EW-1:0] err_cnt;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Window description: win_n[k] out pulses after clock pulse k,
  // win_s[k] an out pulse toggled together with clock pulse k.
  int unsigned   win_n[64];
  bit            win_s[64];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] mdl_words[$];

  typedef struct {
    string       name;
    logic [15:0] n2;
    logic [8:0]  s;
    logic [7:0]  word;
    int          err;
  } vec_t;

  vec_t vecs[7];

  sfq_or2t_readout #(.WORD_W(WW), .ERR_W(EW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .sfq_clk    (sfq_clk),
    .sfq_out    (sfq_out),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accepted-word scoreboard, sampled just before the rising edge
  always @(negedge clk) begin
    #4;
    if (rst_n === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0h, expected none", word_data);
      end else begin
        check("word_accept", 32'(word_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Window-level reference: window k = out pulses after clock k plus any out
  // coincident with clock k+1; bit = count>=1, error when count>=2.
  function automatic int model(input int np, input int orphans);
    logic [WW-1:0] w;
    int b;
    int c;
    int errs;
    w = '0;
    b = 0;
    errs = orphans + (win_s[0] ? 1 : 0);
    mdl_words.delete();
    for (int k = 0; k < np - 1; k++) begin
      c = int'(win_n[k]) + (win_s[k+1] ? 1 : 0);
      if (c >= 1) w[b] = 1'b1;
      if (c >= 2) errs++;
      b++;
      if (b == WW) begin
        mdl_words.push_back(w);
        w = '0;
        b = 0;
      end
    end
    if (errs > (1 << EW) - 1) errs = (1 << EW) - 1;
    return errs;
  endfunction

  task automatic clear_wins();
    for (int k = 0; k < 64; k++) begin
      win_n[k] = 0;
      win_s[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    arm = 1'b0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Each clock pulse period is 12 cycles; out toggles at +4 and +8
  task automatic send_pulses(input int np);
    for (int k = 0; k < np; k++) begin
      @(negedge clk);
      sfq_clk = ~sfq_clk;
      if (win_s[k]) sfq_out = ~sfq_out;
      repeat (4) @(negedge clk);
      if (win_n[k] >= 1) sfq_out = ~sfq_out;
      repeat (4) @(negedge clk);
      if (win_n[k] >= 2) sfq_out = ~sfq_out;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    int e;

    vecs[0] = '{"basic",     16'h4051, 9'h000, 8'h8D, 0};
    vecs[1] = '{"simul",     16'h0000, 9'h010, 8'h08, 0};
    vecs[2] = '{"double",    16'h0800, 9'h000, 8'h20, 1};
    vecs[3] = '{"dbl_simul", 16'h0004, 9'h004, 8'h02, 1};
    vecs[4] = '{"all_ones",  16'h5555, 9'h000, 8'hFF, 0};
    vecs[5] = '{"zeros",     16'h0000, 9'h000, 8'h00, 0};
    vecs[6] = '{"mixed",     16'h2002, 9'h100, 8'hC1, 2};

    // Reset and idle, lines toggling throughout
    repeat (2) @(negedge clk);
    sfq_clk = ~sfq_clk;
    sfq_out = ~sfq_out;
    @(negedge clk);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data",  32'(word_data),  32'd0);
    check("rst_err",   32'(err_cnt),    32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      sfq_clk = ~sfq_clk;
      sfq_out = ~sfq_out;
    end
    repeat (6) @(negedge clk);
    check("idle_valid",   32'(word_valid), 32'd0);
    check("idle_err",     32'(err_cnt),    32'd0);
    check("idle_busy",    32'(busy),       32'd0);
    check("idle_overrun", 32'(overrun),    32'd0);

    // A line level changed during reset must not appear as an orphan
    @(negedge clk);
    rst_n = 1'b0;
    arm = 1'b1;
    sfq_out = ~sfq_out;
    if (sfq_out == 1'b0) sfq_out = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rstrel_err",  32'(err_cnt), 32'd0);
    check("rstrel_busy", 32'(busy),    32'd1);
    arm = 1'b0;

    // Basic capture with conversion latency on the closing pulse
    do_reset();
    clear_wins();
    win_n[0] = 1; win_n[2] = 1; win_n[3] = 1; win_n[7] = 1;
    arm = 1'b1;
    send_pulses(8);
    @(negedge clk);
    sfq_clk = ~sfq_clk;
    @(negedge clk);
    check("lat_1", 32'(word_valid), 32'd0);
    @(negedge clk);
    check("lat_2", 32'(word_valid), 32'd0);
    @(negedge clk);
    check("lat_3", 32'(word_valid), 32'd1);
    check("basic_data", 32'(word_data), 32'h8D);
    arm = 1'b0;

    // Table-driven single-word captures
    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_wins();
      for (int k = 0; k < 8; k++) win_n[k] = 32'(vecs[v].n2[2*k +: 2]);
      for (int k = 0; k < 9; k++) win_s[k] = vecs[v].s[k];
      arm = 1'b1;
      send_pulses(9);
      check({vecs[v].name, "_valid"},   32'(word_valid), 32'd1);
      check({vecs[v].name, "_data"},    32'(word_data),  32'(vecs[v].word));
      check({vecs[v].name, "_err"},     32'(err_cnt),    32'(vecs[v].err));
      check({vecs[v].name, "_overrun"}, 32'(overrun),    32'd0);
      check({vecs[v].name, "_busy"},    32'(busy),       32'd1);
      arm = 1'b0;
      @(negedge clk);
      check({vecs[v].name, "_disarm"},  32'(busy),       32'd0);
    end

    // Orphan, disarm after 5 bits, re-arm with zero windows
    do_reset();
    clear_wins();
    arm = 1'b1;
    @(negedge clk);
    sfq_out = ~sfq_out;
    repeat (5) @(negedge clk);
    check("orphan_err",  32'(err_cnt), 32'd1);
    check("orphan_busy", 32'(busy),    32'd1);
    send_pulses(6);
    arm = 1'b0;
    @(negedge clk);
    check("disarm_busy",  32'(busy),       32'd0);
    check("disarm_valid", 32'(word_valid), 32'd0);
    check("disarm_err",   32'(err_cnt),    32'd1);
    arm = 1'b1;
    send_pulses(9);
    check("rearm_valid", 32'(word_valid), 32'd1);
    check("rearm_data",  32'(word_data),  32'h00);
    check("rearm_err",   32'(err_cnt),    32'd1);
    arm = 1'b0;

    // Backpressure: second word dropped, first held until accepted
    do_reset();
    clear_wins();
    for (int k = 0; k < 9; k++) win_n[k] = 1;
    arm = 1'b1;
    send_pulses(17);
    check("bp_data",    32'(word_data),  32'hFF);
    check("bp_valid",   32'(word_valid), 32'd1);
    check("bp_overrun", 32'(overrun),    32'd1);
    exp_q.push_back(8'hFF);
    word_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_accepted",  32'(word_valid),   32'd0);
    check("bp_drained",   32'(exp_q.size()), 32'd0);
    check("bp_sticky",    32'(overrun),      32'd1);
    arm = 1'b0;

    // Saturation of the 2-bit error counter, then async reset mid-word
    do_reset();
    clear_wins();
    for (int k = 0; k < 5; k++) win_n[k] = 2;
    arm = 1'b1;
    send_pulses(9);
    check("sat_err",  32'(err_cnt),   32'd3);
    check("sat_data", 32'(word_data), 32'h1F);
    clear_wins();
    for (int k = 0; k < 3; k++) win_n[k] = 2;
    send_pulses(8);
    check("sat_hold",    32'(err_cnt),   32'd3);
    check("sat_overrun", 32'(overrun),   32'd1);
    check("sat_keep",    32'(word_data), 32'h1F);
    clear_wins();
    send_pulses(2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   32'(word_valid), 32'd0);
    check("arst_data",    32'(word_data),  32'd0);
    check("arst_err",     32'(err_cnt),    32'd0);
    check("arst_overrun", 32'(overrun),    32'd0);
    check("arst_busy",    32'(busy),       32'd0);
    arm = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized window streams against the reference model
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_wins();
      for (int k = 0; k < 25; k++) begin
        win_n[k] = $urandom_range(0, 2);
        win_s[k] = (k > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      e = model(25, 0);
      foreach (mdl_words[i]) exp_q.push_back(mdl_words[i]);
      word_ready = 1'b1;
      arm = 1'b1;
      send_pulses(25);
      check("rnd_err",     32'(err_cnt),      32'(e));
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
      check("rnd_overrun", 32'(overrun),      32'd0);
      arm = 1'b0;
      exp_q.delete();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
